// File: rtl/alu_exec_unit.sv
// Execute stage: opcode/funct decode to a 4-bit ALU control code, single-cycle ALU,
// and an iterative multiply/divide that writes the architectural HI/LO pair.
`timescale 1ns/1ps
module alu_exec_unit #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_result,
    output logic [3:0]       out_cntl,
    output logic             out_ovf,
    output logic             out_branch,
    output logic             out_illegal,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [1:0]       dbg_state
);

    // Handshake: an operation is taken on a rising edge where in_valid && in_ready;
    // in_ready is high only in IDLE, and nothing presented while it is low is kept.
    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, FIX = 2'd3} state_t;

    localparam logic [3:0] C_AND  = 4'b0000, C_OR   = 4'b0001, C_ADD  = 4'b0010;
    localparam logic [3:0] C_XOR  = 4'b0011, C_SUB  = 4'b0110, C_BNE  = 4'b0111;
    localparam logic [3:0] C_NOR  = 4'b1100, C_SLT  = 4'b1101, C_SLTU = 4'b1110;
    localparam logic [3:0] C_MFHI = 4'b1000, C_MFLO = 4'b1001, C_MULT = 4'b0100;
    localparam logic [3:0] C_DIV  = 4'b0101, C_ILL  = 4'b1111;

    state_t state, state_next;

    logic [3:0]       dec_cntl;
    logic             dec_ill, dec_ovf_en, dec_beq, dec_mul, dec_div, dec_signed;
    logic             accept, last_iter;
    logic [WIDTH-1:0] sum, diff, alu_result, a_mag, b_mag;
    logic             add_ovf, sub_ovf, alu_ovf, alu_branch;

    logic [WIDTH-1:0] work_hi, work_lo, mcand, hi_q, lo_q;
    logic [CNT_W-1:0] cnt;
    logic             md_div, neg_q, neg_r, div0;
    logic [WIDTH:0]   mul_sum, div_shift;
    logic [WIDTH-1:0] div_rem;
    logic             div_ge;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0] fix_hi, fix_lo;

    logic             out_valid_q, out_ovf_q, out_branch_q, out_illegal_q;
    logic [WIDTH-1:0] out_result_q;
    logic [3:0]       out_cntl_q;

    always_comb begin
        dec_cntl   = C_ILL;
        dec_ill    = 1'b0;
        dec_ovf_en = 1'b0;
        dec_beq    = 1'b0;
        dec_mul    = 1'b0;
        dec_div    = 1'b0;
        dec_signed = 1'b0;
        if (opcode == 6'b000000) begin
            case (funct)
                6'b100100: dec_cntl = C_AND;
                6'b100101: dec_cntl = C_OR;
                6'b100000: begin dec_cntl = C_ADD; dec_ovf_en = 1'b1; end
                6'b100001: dec_cntl = C_ADD;
                6'b100010: begin dec_cntl = C_SUB; dec_ovf_en = 1'b1; end
                6'b100011: dec_cntl = C_SUB;
                6'b100110: dec_cntl = C_XOR;
                6'b100111: dec_cntl = C_NOR;
                6'b101010: dec_cntl = C_SLT;
                6'b101011: dec_cntl = C_SLTU;
                6'b010000: dec_cntl = C_MFHI;
                6'b010010: dec_cntl = C_MFLO;
                6'b011000: begin dec_cntl = C_MULT; dec_mul = 1'b1; dec_signed = 1'b1; end
                6'b011001: begin dec_cntl = C_MULT; dec_mul = 1'b1; end
                6'b011010: begin dec_cntl = C_DIV; dec_div = 1'b1; dec_signed = 1'b1; end
                6'b011011: begin dec_cntl = C_DIV; dec_div = 1'b1; end
                default:   dec_ill = 1'b1;
            endcase
        end else begin
            case (opcode)
                6'b001000: begin dec_cntl = C_ADD; dec_ovf_en = 1'b1; end
                6'b001001: dec_cntl = C_ADD;
                6'b001100: dec_cntl = C_AND;
                6'b001101: dec_cntl = C_OR;
                6'b100011: dec_cntl = C_ADD;
                6'b101011: dec_cntl = C_ADD;
                6'b000100: begin dec_cntl = C_SUB; dec_beq = 1'b1; end
                6'b000101: dec_cntl = C_BNE;
                6'b001010: dec_cntl = C_SLT;
                6'b001011: dec_cntl = C_SLTU;
                default:   dec_ill = 1'b1;
            endcase
        end
    end

    always_comb begin
        sum     = op_a + op_b;
        diff    = op_a - op_b;
        add_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
        sub_ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
        alu_ovf = dec_ovf_en && ((dec_cntl == C_ADD) ? add_ovf : sub_ovf);
        alu_branch = dec_beq ? (op_a == op_b) : ((dec_cntl == C_BNE) && (op_a != op_b));
        case (dec_cntl)
            C_AND:   alu_result = op_a & op_b;
            C_OR:    alu_result = op_a | op_b;
            C_ADD:   alu_result = sum;
            C_XOR:   alu_result = op_a ^ op_b;
            C_SUB:   alu_result = diff;
            C_BNE:   alu_result = {{(WIDTH-1){1'b0}}, op_a != op_b};
            C_NOR:   alu_result = ~(op_a | op_b);
            C_SLT:   alu_result = {{(WIDTH-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            C_SLTU:  alu_result = {{(WIDTH-1){1'b0}}, op_a < op_b};
            C_MFHI:  alu_result = hi_q;
            C_MFLO:  alu_result = lo_q;
            default: alu_result = '0;
        endcase
        a_mag = (dec_signed && op_a[WIDTH-1]) ? -op_a : op_a;
        b_mag = (dec_signed && op_b[WIDTH-1]) ? -op_b : op_b;
    end

    assign in_ready  = (state == IDLE);
    assign accept    = in_valid && in_ready;
    assign last_iter = ((state == MUL) || (state == DIV)) && (cnt == CNT_W'(1));

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept && dec_mul) state_next = MUL;
                else if (accept && dec_div) state_next = DIV;
            end
            MUL, DIV: if (cnt == CNT_W'(1)) state_next = FIX;
            FIX: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // One shift-add or restoring-subtract step per cycle on operand magnitudes.
    always_comb begin
        mul_sum   = {1'b0, work_hi} + {1'b0, (work_lo[0] ? mcand : '0)};
        div_shift = {work_hi, work_lo[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, mcand});
        div_rem   = div_shift[WIDTH-1:0] - mcand;
        prod      = {work_hi, work_lo};
        prod_fix  = neg_q ? -prod : prod;
        if (md_div) begin
            fix_lo = div0 ? '1 : (neg_q ? -work_lo : work_lo);
            fix_hi = neg_r ? -work_hi : work_hi;
        end else begin
            fix_hi = prod_fix[2*WIDTH-1:WIDTH];
            fix_lo = prod_fix[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work_hi <= '0; work_lo <= '0; mcand <= '0; cnt <= '0;
            md_div <= 1'b0; neg_q <= 1'b0; neg_r <= 1'b0; div0 <= 1'b0;
            hi_q <= '0; lo_q <= '0;
            out_valid_q <= 1'b0; out_result_q <= '0; out_cntl_q <= '0;
            out_ovf_q <= 1'b0; out_branch_q <= 1'b0; out_illegal_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && (dec_mul || dec_div)) begin
                        cnt     <= CNT_W'(WIDTH);
                        md_div  <= dec_div;
                        neg_q   <= dec_signed && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                        neg_r   <= dec_signed && op_a[WIDTH-1];
                        div0    <= (op_b == '0);
                        work_hi <= '0;
                        work_lo <= dec_div ? a_mag : b_mag;
                        mcand   <= dec_div ? b_mag : a_mag;
                    end else if (accept) begin
                        out_valid_q   <= 1'b1;
                        out_result_q  <= alu_result;
                        out_cntl_q    <= dec_cntl;
                        out_ovf_q     <= alu_ovf;
                        out_branch_q  <= alu_branch;
                        out_illegal_q <= dec_ill;
                    end
                end
                MUL: begin
                    work_hi <= mul_sum[WIDTH:1];
                    work_lo <= {mul_sum[0], work_lo[WIDTH-1:1]};
                    cnt     <= cnt - CNT_W'(1);
                end
                DIV: begin
                    work_hi <= div_ge ? div_rem : div_shift[WIDTH-1:0];
                    work_lo <= {work_lo[WIDTH-2:0], div_ge};
                    cnt     <= cnt - CNT_W'(1);
                end
                FIX: begin
                    hi_q <= fix_hi;
                    lo_q <= fix_lo;
                end
                default: ;
            endcase
            // The completion pulse is registered on the last step so it coincides with FIX.
            if (last_iter) begin
                out_valid_q   <= 1'b1;
                out_result_q  <= '0;
                out_cntl_q    <= md_div ? C_DIV : C_MULT;
                out_ovf_q     <= 1'b0;
                out_branch_q  <= 1'b0;
                out_illegal_q <= 1'b0;
            end
        end
    end

    // During FIX the new HI/LO are already visible alongside the out_valid pulse.
    assign hi          = (state == FIX) ? fix_hi : hi_q;
    assign lo          = (state == FIX) ? fix_lo : lo_q;
    assign out_valid   = out_valid_q;
    assign out_result  = out_result_q;
    assign out_cntl    = out_cntl_q;
    assign out_ovf     = out_ovf_q;
    assign out_branch  = out_branch_q;
    assign out_illegal = out_illegal_q;
    assign dbg_state   = state;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed corner cases plus random operations, checked by a
// queue-based scoreboard fed from a plain-arithmetic reference model of HI/LO and the ALU.
`timescale 1ns/1ps
module tb_alu_exec_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready;
    logic [5:0]   opcode, funct;
    logic [W-1:0] op_a, op_b;
    logic         out_valid, out_ovf, out_branch, out_illegal;
    logic [W-1:0] out_result, hi, lo;
    logic [3:0]   out_cntl;
    logic [1:0]   dbg_state;

    alu_exec_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct(funct), .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid), .out_result(out_result), .out_cntl(out_cntl),
        .out_ovf(out_ovf), .out_branch(out_branch), .out_illegal(out_illegal),
        .hi(hi), .lo(lo), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [W-1:0] result;
        logic [3:0]   cntl;
        logic         ovf, branch, illegal, chk_result, chk_cntl;
        logic [W-1:0] hi, lo;
        logic [31:0]  due;
    } exp_t;

    exp_t         exp_q[$];
    exp_t         mon_e;
    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    logic [5:0] r_fn  [12] = '{6'b100100, 6'b100101, 6'b100000, 6'b100001, 6'b100010, 6'b100011,
                               6'b100110, 6'b100111, 6'b101010, 6'b101011, 6'b010000, 6'b010010};
    logic [5:0] i_opc [10] = '{6'b001000, 6'b001001, 6'b001100, 6'b001101, 6'b100011,
                               6'b101011, 6'b000100, 6'b000101, 6'b001010, 6'b001011};
    logic [5:0] md_fn [4]  = '{6'b011000, 6'b011001, 6'b011010, 6'b011011};

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: MIPS-style semantics in 64-bit arithmetic; updates the model HI/LO.
    task automatic model(input logic [5:0] opc, input logic [5:0] fn,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         output exp_t e, output int lat);
        longint sa, sb, s, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e = '0;
        e.cntl = 4'hF; e.illegal = 1'b0; e.chk_result = 1'b1; e.chk_cntl = 1'b1;
        lat = 1;
        if (opc == 6'b000000) begin
            case (fn)
                6'b100100: begin e.cntl = 4'b0000; e.result = a & b; end
                6'b100101: begin e.cntl = 4'b0001; e.result = a | b; end
                6'b100000, 6'b100001: begin
                    e.cntl = 4'b0010; e.result = a + b; s = sa + sb;
                    e.ovf = (fn == 6'b100000) && (s > 64'sd2147483647 || s < -64'sd2147483648);
                end
                6'b100010, 6'b100011: begin
                    e.cntl = 4'b0110; e.result = a - b; s = sa - sb;
                    e.ovf = (fn == 6'b100010) && (s > 64'sd2147483647 || s < -64'sd2147483648);
                end
                6'b100110: begin e.cntl = 4'b0011; e.result = a ^ b; end
                6'b100111: begin e.cntl = 4'b1100; e.result = ~(a | b); end
                6'b101010: begin e.cntl = 4'b1101; e.result = (sa < sb) ? 1 : 0; end
                6'b101011: begin e.cntl = 4'b1110; e.result = (a < b) ? 1 : 0; end
                6'b010000: begin e.chk_cntl = 1'b0; e.result = m_hi; end
                6'b010010: begin e.chk_cntl = 1'b0; e.result = m_lo; end
                6'b011000, 6'b011001: begin
                    e.chk_cntl = 1'b0; lat = W + 1;
                    if (fn == 6'b011000) p = sa * sb;
                    else p = {32'b0, a} * {32'b0, b};
                    m_hi = p[63:32]; m_lo = p[31:0];
                end
                6'b011010, 6'b011011: begin
                    e.chk_cntl = 1'b0; lat = W + 1;
                    if (b == 0) begin
                        m_lo = '1; m_hi = a;
                    end else if (fn == 6'b011010) begin
                        q = sa / sb; r = sa % sb;
                        m_lo = q[31:0]; m_hi = r[31:0];
                    end else begin
                        m_lo = a / b; m_hi = a % b;
                    end
                end
                default: e.illegal = 1'b1;
            endcase
        end else begin
            case (opc)
                6'b001000, 6'b001001: begin
                    e.cntl = 4'b0010; e.result = a + b; s = sa + sb;
                    e.ovf = (opc == 6'b001000) && (s > 64'sd2147483647 || s < -64'sd2147483648);
                end
                6'b001100: begin e.cntl = 4'b0000; e.result = a & b; end
                6'b001101: begin e.cntl = 4'b0001; e.result = a | b; end
                6'b100011, 6'b101011: begin e.cntl = 4'b0010; e.result = a + b; end
                6'b000100: begin e.cntl = 4'b0110; e.branch = (a == b); e.chk_result = 1'b0; end
                6'b000101: begin e.cntl = 4'b0111; e.branch = (a != b); e.chk_result = 1'b0; end
                6'b001010: begin e.cntl = 4'b1101; e.result = (sa < sb) ? 1 : 0; end
                6'b001011: begin e.cntl = 4'b1110; e.result = (a < b) ? 1 : 0; end
                default: e.illegal = 1'b1;
            endcase
        end
        e.hi = m_hi;
        e.lo = m_lo;
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after the accept edge.
    task automatic issue(input logic [5:0] opc, input logic [5:0] fn,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        int   guard, lat;
        exp_t e;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL ready_timeout: in_ready stayed 0 for %0d cycles, required 1", guard);
        end else begin
            opcode = opc; funct = fn; op_a = a; op_b = b; in_valid = 1'b1;
            model(opc, fn, a, b, e, lat);
            e.due = cyc + lat;
            exp_q.push_back(e);
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
    endtask

    function automatic logic [W-1:0] rand_op();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return 1;
            2: return '1;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_out_valid: got out_valid=1 at cycle %0d, required none", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("latency_cycle", cyc, mon_e.due);
                if (mon_e.chk_result) chk("out_result", out_result, mon_e.result);
                if (mon_e.chk_cntl) chk("out_cntl", {28'b0, out_cntl}, {28'b0, mon_e.cntl});
                chk("out_ovf", {31'b0, out_ovf}, {31'b0, mon_e.ovf});
                chk("out_branch", {31'b0, out_branch}, {31'b0, mon_e.branch});
                chk("out_illegal", {31'b0, out_illegal}, {31'b0, mon_e.illegal});
                chk("hi", hi, mon_e.hi);
                chk("lo", lo, mon_e.lo);
            end
        end
    end

    initial begin
        #2_000_000;
        checks++; errors++;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int guard, r;
        logic [5:0] opc, fn;
        rst = 1'b1; in_valid = 1'b0; opcode = '0; funct = '0; op_a = '0; op_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'b0, out_valid}, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_cntl", {28'b0, out_cntl}, 0);
        chk("rst_flags", {29'b0, out_ovf, out_branch, out_illegal}, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_in_ready", {31'b0, in_ready}, 1);
        chk("rst_state", {30'b0, dbg_state}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        issue(6'b000000, 6'b100000, 32'h7FFF_FFFF, 32'h1);
        issue(6'b000000, 6'b100001, 32'h7FFF_FFFF, 32'h1);
        issue(6'b000000, 6'b101010, 32'hFFFF_FFFF, 32'h1);
        issue(6'b000000, 6'b101011, 32'hFFFF_FFFF, 32'h1);
        issue(6'b000101, 6'b000000, 32'd5, 32'd5);
        issue(6'b000100, 6'b000000, 32'd5, 32'd5);
        issue(6'b111111, 6'b000000, 32'h1234, 32'h5678);
        issue(6'b000000, 6'b100010, 32'h8000_0000, 32'h1);

        // Multiply with junk held on the inputs while busy; it must be ignored.
        issue(6'b000000, 6'b011000, 32'hFFFF_FFFE, 32'd3);
        chk("busy_in_ready", {31'b0, in_ready}, 0);
        opcode = 6'b000000; funct = 6'b100000; op_a = 32'd1; op_b = 32'd1; in_valid = 1'b1;
        guard = 0;
        @(negedge clk);
        while (!out_valid && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b0;
        chk("mult_done_seen", {31'b0, out_valid}, 1);
        chk("pulse_in_ready", {31'b0, in_ready}, 0);
        @(posedge clk); #1;
        chk("after_pulse_in_ready", {31'b0, in_ready}, 1);

        issue(6'b000000, 6'b011011, 32'd7, 32'd0);
        issue(6'b000000, 6'b011010, 32'hFFFF_FFF9, 32'd2);
        issue(6'b000000, 6'b010010, 32'd0, 32'd0);
        issue(6'b000000, 6'b011010, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(6'b000000, 6'b010000, 32'd0, 32'd0);
        issue(6'b000000, 6'b011010, 32'hFFFF_FFF9, 32'd0);

        // Reset in the middle of a multiply: aborted, no HI/LO write, no completion.
        issue(6'b000000, 6'b011001, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        exp_q.delete();
        m_hi = '0; m_lo = '0;
        chk("midrst_out_valid", {31'b0, out_valid}, 0);
        chk("midrst_hi", hi, 0);
        chk("midrst_lo", lo, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_in_ready", {31'b0, in_ready}, 1);
        repeat (40) @(posedge clk);
        #1;
        issue(6'b000000, 6'b010010, 32'd0, 32'd0);

        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 99);
            if (r < 8) begin
                opc = 6'b000000; fn = md_fn[$urandom_range(0, 3)];
            end else if (r < 14) begin
                opc = 6'($urandom_range(0, 63)); fn = 6'($urandom_range(0, 63));
            end else if (r < 60) begin
                opc = 6'b000000; fn = r_fn[$urandom_range(0, 11)];
            end else begin
                opc = i_opc[$urandom_range(0, 9)]; fn = 6'($urandom_range(0, 63));
            end
            issue(opc, fn, rand_op(), rand_op());
            if ($urandom_range(0, 9) == 0) begin
                @(posedge clk); #1;
            end
        end

        repeat (50) @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
